// File: rtl/seg_scan_n.sv
// Time-multiplexed N-digit seven-segment scanner with a load-strobed shadow, leading-zero blanking
// and optional per-digit blink, compiled in when SEG_BLINK_EN is defined.
module seg_scan_n #(
    parameter int DIGITS      = 4,
    parameter int CLK_DIV     = 50000,
    parameter int BLINK_TICKS = 250
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [4*DIGITS-1:0]   num,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  colon,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  dp
);
    localparam int TW = $clog2(CLK_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [TW-1:0]         tick_cnt;
    logic                  tick;
    logic [IW-1:0]         idx, slot;
    logic                  active;
    logic [4*DIGITS-1:0]   num_s, num_d;
    logic [DIGITS-1:0]     dp_s, dp_d;
    logic                  colon_s, colon_d, blank_d;

    assign tick = (tick_cnt == TW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            num_s   <= '0;
            dp_s    <= '0;
            colon_s <= 1'b0;
        end else if (load) begin
            num_s   <= num;
            dp_s    <= dp_in;
            colon_s <= colon;
        end
    end

    // Display state changes only on a scan tick; slot holds the digit shown until the next tick.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            tick_cnt <= '0;
            idx      <= '0;
            slot     <= '0;
            active   <= 1'b0;
            num_d    <= '0;
            dp_d     <= '0;
            colon_d  <= 1'b0;
            blank_d  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                idx     <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
                slot    <= idx;
                active  <= 1'b1;
                num_d   <= num_s;
                dp_d    <= dp_s;
                colon_d <= colon_s;
                blank_d <= blank_lz;
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int BW = $clog2(BLINK_TICKS + 1);

    logic [BW-1:0]     blink_cnt;
    logic              phase;
    logic [DIGITS-1:0] blink_d;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
            blink_d   <= '0;
        end else if (tick) begin
            blink_d <= blink_mask;
            if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_blink;
    assign unused_blink = ^{blink_mask, (BLINK_TICKS > 0)};
`endif

    logic [3:0]        digit;
    logic              dp_bit, upper_zero, lz, blink_bit;
    logic [6:0]        glyph;
    logic [7:0]        seg_nx;
    logic [DIGITS-1:0] an_nx;
    logic              dp_nx;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        digit      = 4'd0;
        dp_bit     = 1'b0;
        lz         = 1'b0;
        blink_bit  = 1'b0;
        upper_zero = 1'b1;
        an_nx      = '1;
        // Walk from the most significant digit so upper_zero covers digits i..DIGITS-1.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (num_d[4*i +: 4] == 4'd0);
            if (IW'(i) == slot) begin
                digit    = num_d[4*i +: 4];
                dp_bit   = dp_d[i];
                lz       = blank_d && (i != 0) && upper_zero;
                an_nx[i] = 1'b0;
`ifdef SEG_BLINK_EN
                blink_bit = blink_d[i];
`endif
            end
        end

        case (digit)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase

        seg_nx = lz ? 8'hFF : {~dp_bit, glyph};
        dp_nx  = ~colon_d;

`ifdef SEG_BLINK_EN
        if (phase && blink_bit) begin
            seg_nx = 8'hFF;
            an_nx  = '1;
        end
        if (phase && blink_d[0]) dp_nx = 1'b1;
`else
        blink_bit = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            seg <= 8'hFF;
            an  <= '1;
            dp  <= 1'b1;
        end else if (active) begin
            seg <= seg_nx;
            an  <= an_nx;
            dp  <= dp_nx;
        end
    end
endmodule

// File: tb/tb_seg_scan_n.sv
// Scoreboard bench for seg_scan_n: a spec-level model pushes one expected slot per scan tick,
// and a monitor checks every cycle of every displayed slot against it.
module tb_seg_scan_n;
    localparam int DIGITS      = 4;
    localparam int CLK_DIV     = 4;
    localparam int BLINK_TICKS = 2;
`ifdef SEG_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    // Lit segments per hex value, active-high, bit 0 = segment a.
    localparam logic [6:0] LIT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic                  clk = 1'b0;
    logic                  clr = 1'b0;
    logic [4*DIGITS-1:0]   num = '0;
    logic [DIGITS-1:0]     dp_in = '0;
    logic                  colon = 1'b0;
    logic                  load = 1'b0;
    logic                  blank_lz = 1'b0;
    logic [DIGITS-1:0]     blink_mask = '0;
    logic [7:0]            seg;
    logic [DIGITS-1:0]     an;
    logic                  dp;

    always #5 clk = ~clk;

    seg_scan_n #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLINK_TICKS(BLINK_TICKS)) dut (
        .clk(clk), .clr(clr), .num(num), .dp_in(dp_in), .colon(colon), .load(load),
        .blank_lz(blank_lz), .blink_mask(blink_mask), .seg(seg), .an(an), .dp(dp)
    );

    typedef struct packed {
        logic [DIGITS-1:0] an;
        logic [7:0]        seg;
        logic              dp;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_an"}, 32'(an), 32'(4'b1111));
        check({tag, "_seg"}, 32'(seg), 32'h0000_00FF);
        check({tag, "_dp"}, 32'(dp), 32'd1);
    endtask

    // Expected outputs for the slot opened by scan tick t (1-based since reset release).
    function automatic exp_t expect_slot(input int t, input logic [4*DIGITS-1:0] n,
                                         input logic [DIGITS-1:0] dps, input logic col,
                                         input logic bl, input logic [DIGITS-1:0] mask);
        exp_t e;
        int   d;
        int   v;
        bit   lead;
        d    = (t - 1) % DIGITS;
        v    = int'(n[4*d +: 4]);
        lead = bl && (d != 0) && ((n >> (4*d)) == '0);
        e.an    = '1;
        e.an[d] = 1'b0;
        e.seg   = lead ? 8'hFF : {~dps[d], ~LIT[v]};
        e.dp    = ~col;
        if (BLINK_ON && ((t / BLINK_TICKS) % 2 == 1)) begin
            if (mask[d]) begin
                e.seg = 8'hFF;
                e.an  = '1;
            end
            if (mask[0]) e.dp = 1'b1;
        end
        return e;
    endfunction

    task automatic stim(input int mode, input int edges);
        for (int n = 1; n <= edges; n++) begin
            @(posedge clk);
            #1;
            load = 1'b0;
            case (mode)
                0: if (n == 1) begin
                       num = 16'h1234; dp_in = 4'b0100; colon = 1'b1; blink_mask = 4'b0001; load = 1'b1;
                   end
                1: if (n == 1) begin
                       num = 16'h0050; blank_lz = 1'b1; load = 1'b1;
                   end else if (n == 4*CLK_DIV + 1) begin
                       num = 16'h0000; load = 1'b1;
                   end
                2: if (n == 1) begin
                       num = 16'h1234; load = 1'b1;
                   end else if (n == 3*CLK_DIV - 1) begin
                       num = 16'h9999; load = 1'b1;
                   end
                default: begin
                    for (int i = 0; i < DIGITS; i++)
                        num[4*i +: 4] = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom);
                    dp_in      = DIGITS'($urandom);
                    colon      = 1'($urandom);
                    blank_lz   = 1'($urandom);
                    blink_mask = DIGITS'($urandom);
                    load       = ($urandom_range(2) == 0);
                end
            endcase
        end
        load = 1'b0;
    endtask

    task automatic model(input int edges);
        logic [4*DIGITS-1:0] sh_num = '0;
        logic [DIGITS-1:0]   sh_dp  = '0;
        logic                sh_col = 1'b0;
        for (int n = 1; n <= edges; n++) begin
            @(posedge clk);
            // The display takes the shadow as it stood before this edge's load.
            if (n % CLK_DIV == 0)
                sb.push_back(expect_slot(n / CLK_DIV, sh_num, sh_dp, sh_col, blank_lz, blink_mask));
            if (load) begin
                sh_num = num;
                sh_dp  = dp_in;
                sh_col = colon;
            end
        end
    endtask

    task automatic monitor(input int nslots);
        exp_t e, got, rec;
        bit   mism;
        for (int m = 1; m <= CLK_DIV; m++) begin
            @(negedge clk);
            if (m == CLK_DIV) check_idle("pre_first_tick");
        end
        for (int k = 0; k < nslots; k++) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: slot %0d has no expected entry", k);
                e = '1;
            end else begin
                e = sb.pop_front();
            end
            mism = 1'b0;
            rec  = '0;
            for (int c = 0; c < CLK_DIV; c++) begin
                @(negedge clk);
                got = {an, seg, dp};
                if (!mism) rec = got;
                if (got !== e) mism = 1'b1;
            end
            check($sformatf("slot%0d", k), 32'(rec), 32'(e));
        end
    endtask

    task automatic run_phase(input int mode, input int nslots);
        sb.delete();
        num = '0; dp_in = '0; colon = 1'b0; load = 1'b0; blank_lz = 1'b0; blink_mask = '0;
        #1;
        check_idle($sformatf("reset_m%0d", mode));
        @(negedge clk);
        clr = 1'b1;
        fork
            stim(mode, (nslots + 1) * CLK_DIV);
            model(nslots * CLK_DIV);
            monitor(nslots);
        join
        @(negedge clk);
        #2 clr = 1'b0;
        #1 check_idle($sformatf("end_m%0d", mode));
        check("sb_leftover", 32'(sb.size()), 32'd0);
    endtask

    task automatic mid_reset();
        num = '0; dp_in = '0; colon = 1'b1; load = 1'b0; blank_lz = 1'b0; blink_mask = '0;
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1 num = 16'h1234; load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        repeat (3*CLK_DIV) @(posedge clk);
        @(negedge clk);
        check("mid_slot2_an", 32'(an), 32'(4'b1011));
        check("mid_slot2_seg", 32'(seg), 32'h0000_00A4);
        check("mid_slot2_dp", 32'(dp), 32'd0);
        #1 clr = 1'b0;
        #1 check_idle("async_clr");
    endtask

    initial begin
        repeat (3) @(negedge clk);
        run_phase(0, 8);
        run_phase(1, 8);
        mid_reset();
        run_phase(2, 6);
        run_phase(3, 40);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
